// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for the SingleCycleALU: runs EXEC, optional STORE and LOAD phases per command
// and returns the ALU result, memory readback and a store/load consistency flag.
module alu_cmd_sequencer #(
    parameter int unsigned LOAD_WAIT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_a,
    input  logic [1:0] cmd_b,
    input  logic [2:0] cmd_op,
    input  logic [3:0] cmd_addr,
    input  logic       cmd_store,
    input  logic       cmd_load,
    output logic [1:0] alu_a,
    output logic [1:0] alu_b,
    output logic [2:0] alu_op,
    output logic [3:0] alu_address,
    output logic [2:0] alu_memop,
    input  logic [2:0] alu_y,
    input  logic [2:0] alu_memout,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [2:0] rsp_y,
    output logic [2:0] rsp_mem,
    output logic       rsp_mismatch,
    output logic       busy,
    output logic [7:0] cmd_count,
    output logic [7:0] err_count
);

    typedef enum logic [2:0] {StIdle, StExec, StStore, StLoad, StResp} state_e;

    localparam logic [2:0] MemIdle  = 3'b000;
    localparam logic [2:0] MemStore = 3'b001;
    localparam logic [2:0] MemLoad  = 3'b010;

    state_e     state_q, state_d;
    logic       store_q, load_q;
    logic [1:0] wait_q;
    logic       load_done;
    logic       cmd_hs, rsp_hs;
    logic [2:0] memop_d;

    assign cmd_hs    = cmd_valid & cmd_ready;
    assign rsp_hs    = rsp_valid & rsp_ready;
    assign load_done = (wait_q == 2'(LOAD_WAIT));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (cmd_hs) state_d = StExec;
            StExec:  state_d = store_q ? StStore : (load_q ? StLoad : StResp);
            StStore: state_d = load_q ? StLoad : StResp;
            StLoad:  if (load_done) state_d = StResp;
            StResp:  if (rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // memop is registered from the next state so it lines up with the phase it belongs to.
    always_comb begin
        cmd_ready = rst_n & (state_q == StIdle);
        busy      = (state_q != StIdle);
        memop_d   = MemIdle;
        unique case (state_d)
            StStore: memop_d = MemStore;
            StLoad:  memop_d = MemLoad;
            default: memop_d = MemIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_a        <= '0;
            alu_b        <= '0;
            alu_op       <= '0;
            alu_address  <= '0;
            alu_memop    <= MemIdle;
            store_q      <= 1'b0;
            load_q       <= 1'b0;
            wait_q       <= '0;
            rsp_valid    <= 1'b0;
            rsp_y        <= '0;
            rsp_mem      <= '0;
            rsp_mismatch <= 1'b0;
            cmd_count    <= '0;
            err_count    <= '0;
        end else begin
            alu_memop <= memop_d;
            rsp_valid <= (state_d == StResp);
            if (cmd_hs) begin
                alu_a        <= cmd_a;
                alu_b        <= cmd_b;
                alu_op       <= cmd_op;
                alu_address  <= cmd_addr;
                store_q      <= cmd_store;
                load_q       <= cmd_load;
                rsp_mem      <= '0;
                rsp_mismatch <= 1'b0;
            end
            if (state_q == StExec) begin
                rsp_y <= alu_y;
            end
            if (state_q == StLoad) begin
                if (load_done) begin
                    wait_q       <= '0;
                    rsp_mem      <= alu_memout;
                    rsp_mismatch <= store_q & (alu_memout != rsp_y);
                end else begin
                    wait_q <= wait_q + 2'd1;
                end
            end
            if (rsp_hs) begin
                cmd_count <= cmd_count + 8'd1;
                if (rsp_mismatch && err_count != 8'hff) begin
                    err_count <= err_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Randomized self-checking bench for alu_cmd_sequencer with a behavioural ALU/memory environment
// and a per-command reference model.
module tb_alu_cmd_sequencer;

    localparam int unsigned LW = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_a = '0, cmd_b = '0;
    logic [2:0] cmd_op = '0;
    logic [3:0] cmd_addr = '0;
    logic       cmd_store = 1'b0, cmd_load = 1'b0;
    logic [1:0] alu_a, alu_b;
    logic [2:0] alu_op, alu_memop, alu_y, alu_memout;
    logic [3:0] alu_address;
    logic       rsp_valid, rsp_ready = 1'b1;
    logic [2:0] rsp_y, rsp_mem;
    logic       rsp_mismatch, busy;
    logic [7:0] cmd_count, err_count;

    logic [2:0] stub_mem [16];
    logic [2:0] ref_mem [16];
    logic       corrupt = 1'b0;
    int         n_checks = 0;
    int         n_errors = 0;
    int         exp_cmd = 0;
    int         exp_err = 0;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.LOAD_WAIT(LW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
        .cmd_store(cmd_store), .cmd_load(cmd_load),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_address(alu_address),
        .alu_memop(alu_memop), .alu_y(alu_y), .alu_memout(alu_memout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_y(rsp_y), .rsp_mem(rsp_mem), .rsp_mismatch(rsp_mismatch),
        .busy(busy), .cmd_count(cmd_count), .err_count(err_count)
    );

    // Stand-in for the SingleCycleALU: 3-bit result of 2-bit operands.
    function automatic logic [2:0] alu_f(input logic [1:0] a, input logic [1:0] b,
                                         input logic [2:0] op);
        int ia, ib, r;
        ia = int'(a);
        ib = int'(b);
        case (op)
            3'd0:    r = ia + ib;
            3'd1:    r = ia - ib;
            3'd2:    r = ia & ib;
            3'd3:    r = ia | ib;
            3'd4:    r = ia ^ ib;
            3'd5:    r = ia * 2;
            3'd6:    r = (ia < ib) ? 1 : 0;
            default: r = 7;
        endcase
        return 3'(r & 7);
    endfunction

    assign alu_y      = alu_f(alu_a, alu_b, alu_op);
    assign alu_memout = corrupt ? 3'b000 : stub_mem[alu_address];

    always @(posedge clk) begin
        if (alu_memop == 3'b001) stub_mem[alu_address] <= alu_y;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic finish_sim();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {alu_a, alu_b, alu_op, alu_address, alu_memop, rsp_y, rsp_mem, rsp_mismatch,
                    rsp_valid, cmd_count, err_count, busy}, 64'd0);
    endtask

    task automatic run_cmd(input logic [1:0] a, input logic [1:0] b, input logic [2:0] op,
                           input logic [3:0] addr, input logic st, input logic ld,
                           input logic corr, input int bp);
        logic [2:0]  ey, em;
        logic        emm;
        logic [63:0] seq_got, seq_exp;
        int          exp_lat, lat, n_got, n_exp;
        // Reference: what the command should return, derived from the phase rules.
        ey = alu_f(a, b, op);
        if (st) ref_mem[addr] = ey;
        em  = ld ? (corr ? 3'b000 : ref_mem[addr]) : 3'b000;
        emm = st && ld && (em != ey);
        exp_lat = 2 + (st ? 1 : 0) + (ld ? 1 + int'(LW) : 0);
        seq_exp = 64'd0;
        n_exp = 1;
        if (st) begin
            seq_exp = (seq_exp << 3) | 64'd1;
            n_exp++;
        end
        if (ld) begin
            for (int i = 0; i < 1 + int'(LW); i++) begin
                seq_exp = (seq_exp << 3) | 64'd2;
                n_exp++;
            end
        end
        seq_exp = seq_exp << 3;
        n_exp++;

        corrupt   = corr;
        cmd_a     = a;
        cmd_b     = b;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_store = st;
        cmd_load  = ld;
        cmd_valid = 1'b1;
        rsp_ready = (bp == 0);
        check("cmd_ready_idle", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat = 1;
        seq_got = 64'd0;
        n_got = 0;
        check("exec_operands", {alu_a, alu_b, alu_op, alu_address}, {a, b, op, addr});
        while (!rsp_valid && lat < 20) begin
            seq_got = (seq_got << 3) | 64'(alu_memop);
            n_got++;
            check("cmd_ready_busy", {cmd_ready, busy}, 2'b01);
            @(posedge clk); #1;
            lat++;
        end
        seq_got = (seq_got << 3) | 64'(alu_memop);
        n_got++;
        check("rsp_latency", lat, exp_lat);
        if (!rsp_valid) begin
            $display("FAIL rsp_timeout: got no rsp_valid expected rsp_valid within 20 cycles");
            n_errors++;
            finish_sim();
        end
        check("memop_seq", seq_got, seq_exp);
        check("memop_len", n_got, n_exp);
        check("rsp_fields", {rsp_y, rsp_mem, rsp_mismatch}, {ey, em, emm});

        for (int i = 0; i < bp; i++) begin
            cmd_valid = (i == 0);
            cmd_a     = ~a;
            @(posedge clk); #1;
            check("bp_hold", {rsp_valid, rsp_y, rsp_mem, rsp_mismatch, cmd_ready},
                  {1'b1, ey, em, emm, 1'b0});
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        exp_cmd = (exp_cmd + 1) % 256;
        if (emm && exp_err < 255) exp_err++;
        check("post_rsp_idle", {cmd_ready, rsp_valid, busy, alu_memop}, {1'b1, 1'b0, 1'b0, 3'b000});
        check("cmd_count", cmd_count, exp_cmd);
        check("err_count", err_count, exp_err);
        corrupt = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        exp_cmd = 0;
        exp_err = 0;
        check_all_zero("reset_outputs");
        check("reset_cmd_ready", cmd_ready, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_reset", {cmd_ready, busy, rsp_valid}, 3'b100);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            stub_mem[i] = 3'b000;
            ref_mem[i]  = 3'b000;
        end
        do_reset();

        // Directed cases.
        run_cmd(2'b01, 2'b10, 3'b000, 4'd1, 1'b1, 1'b1, 1'b0, 0);
        run_cmd(2'b10, 2'b01, 3'b001, 4'd2, 1'b1, 1'b1, 1'b0, 0);
        run_cmd(2'b00, 2'b00, 3'b000, 4'd1, 1'b0, 1'b1, 1'b0, 0);
        run_cmd(2'b01, 2'b10, 3'b000, 4'd3, 1'b1, 1'b1, 1'b1, 0);
        run_cmd(2'b11, 2'b10, 3'b100, 4'd4, 1'b1, 1'b0, 1'b0, 5);
        run_cmd(2'b11, 2'b11, 3'b000, 4'd6, 1'b0, 1'b0, 1'b0, 0);

        // Reset during STORE aborts the command.
        cmd_a = 2'b11; cmd_b = 2'b01; cmd_op = 3'b000; cmd_addr = 4'd5;
        cmd_store = 1'b1; cmd_load = 1'b1; cmd_valid = 1'b1; rsp_ready = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        check("store_phase", alu_memop, 3'b001);
        ref_mem[5] = alu_f(2'b11, 2'b01, 3'b000);
        rst_n = 1'b0;
        @(posedge clk); #1;
        exp_cmd = 0;
        exp_err = 0;
        check_all_zero("midop_reset");
        check("midop_cmd_ready", cmd_ready, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("midop_recover", {cmd_ready, rsp_valid, alu_memop}, {1'b1, 1'b0, 3'b000});
        run_cmd(2'b00, 2'b00, 3'b111, 4'd5, 1'b0, 1'b1, 1'b0, 0);

        // Randomized commands.
        for (int n = 0; n < 60; n++) begin
            run_cmd(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 5) == 0), int'($urandom_range(0, 3)));
        end

        // Counter wrap and saturation.
        do_reset();
        for (int n = 0; n < 256; n++) begin
            run_cmd(2'b01, 2'b10, 3'b000, 4'd7, 1'b1, 1'b1, 1'b1, 0);
        end
        check("wrap_cmd_count", cmd_count, 8'd0);
        check("sat_err_count", err_count, 8'd255);

        finish_sim();
    end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command-driven sequencer that drives the SingleCycleALU datapath and memory ports from a valid/ready command stream, replacing hand-written stimulus. Each accepted command runs an EXEC phase (ALU op), an optional STORE phase (write result to memory) and an optional LOAD phase (read it back). It then returns the captured ALU result, the memory readback and a store/load consistency flag on a valid/ready response port. It sits between a host/command source and the SingleCycleALU instance.

## Interface
- LOAD_WAIT, default 1: extra cycles the LOAD phase holds MemOp=010 before capturing alu_memout (0..3)
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_a, cmd_b  in  2 each  ALU operands
- cmd_op  in  3  ALU opcode
- cmd_addr  in  4  memory address
- cmd_store  in  1  run STORE phase
- cmd_load  in  1  run LOAD phase
- alu_a, alu_b  out  2 each  to ALU A/B
- alu_op  out  3  to ALU Op
- alu_address  out  4  to ALU Address
- alu_memop  out  3  to ALU MemOp (000 idle, 001 store, 010 load)
- alu_y  in  3  ALU Y
- alu_memout  in  3  ALU MemOut
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_y  out  3  ALU result captured in EXEC
- rsp_mem  out  3  memory readback (0 if no LOAD)
- rsp_mismatch  out  1  store and load both run and rsp_mem != rsp_y
- busy  out  1  state != IDLE
- cmd_count  out  8  completed responses, wraps 255->0
- err_count  out  8  responses with rsp_mismatch=1, saturates at 255

## Operation
- States: IDLE, EXEC, STORE, LOAD, RESP.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch all cmd_* fields; go to EXEC.
- EXEC (1 cycle): alu_a/b/op/address = latched values, alu_memop=000. At end of cycle, capture alu_y into rsp_y. Next state is STORE if store, else LOAD if load, else RESP.
- STORE (1 cycle): alu_memop=001; operands, op and address held. Next state is LOAD if load, else RESP.
- LOAD (1+LOAD_WAIT cycles, internal counter): alu_memop=010. Capture alu_memout into rsp_mem on the final cycle's edge, then go to RESP.
- RESP: alu_memop=000; rsp_valid=1. rsp_y, rsp_mem and rsp_mismatch stay stable until rsp_ready. On handshake: cmd_count+1, err_count+1 if mismatch (saturating), go to IDLE.
- rsp_mismatch = store & load & (rsp_mem != rsp_y); otherwise 0.
- alu_a/b/op/address keep their last values outside EXEC/STORE/LOAD. alu_memop is 000 in IDLE and RESP.
- cmd_ready is 0 in every non-IDLE state. Commands are never queued or dropped. cmd_valid while busy has no effect.

## Timing
- Reset (rst_n low at an edge) sets state=IDLE and clears alu_a, alu_b, alu_op, alu_address, alu_memop, rsp_y, rsp_mem, rsp_mismatch, rsp_valid, cmd_count and err_count to 0. busy=0. cmd_ready is forced 0 while rst_n=0.
- Handshake in cycle n gives EXEC in n+1, STORE in n+2 if store, then LOAD, then RESP.
- rsp_valid first cycle:
  - n+2 with no store/load
  - n+3 with store only
  - n+3+LOAD_WAIT with load only
  - n+4+LOAD_WAIT with store and load
- After RESP handshake in cycle m, IDLE in m+1, so the next command is accepted no earlier than m+1 (one-cycle bubble).
- Reset mid-operation aborts the command: alu_memop=000 from the next cycle, no response is issued, counters are cleared.
- cmd_count wraps 255->0. err_count holds at 255.
- All outputs are registered except cmd_ready and busy, which decode from state.

## Test plan
- Add and round-trip: cmd_a=01, cmd_b=10, cmd_op=000, cmd_addr=0001, store=1, load=1, LOAD_WAIT=1, rsp_ready=1. Expect alu_memop sequence 000, 001, 010, 010, 000; rsp_valid at n+5; rsp_y=011, rsp_mem=011, rsp_mismatch=0, cmd_count=1.
- Subtract at second address: cmd_a=10, cmd_b=01, cmd_op=001, cmd_addr=0010, store+load. Expect rsp_y=001, rsp_mem=001. A follow-up load-only command to 0001 returns rsp_mem=011 and mismatch=0.
- Mismatch: the bench memory model corrupts readback to 000 for a store+load with result 011. Expect rsp_mismatch=1 and err_count=1. 256 such commands leave err_count=255 and cmd_count=0 (wrapped).
- Back-pressure: hold rsp_ready=0 for 5 cycles in RESP. Expect rsp_* stable, cmd_ready=0, a cmd_valid pulse ignored, and acceptance in the cycle after the rsp handshake.
- Reset mid-op: assert rst_n=0 during STORE. Expect every output listed under reset at 0 on the next edge, no rsp_valid, and cmd_ready=1 one cycle after rst_n returns high.
- No-mem command: store=0, load=0. Expect rsp_valid at n+2, rsp_mem=000, alu_memop never nonzero.
